serv_bufreg_ctrl: RTL
=====================

Name: serv_bufreg_ctrl

Overview:
Sequencer for the bit-serial buffer register in the SERV core. On a start request it runs an init phase that accumulates rs1+imm (address) or the shift operand into the buffer register. It then runs either a data-bus wait phase for loads and stores, or a coarse-shift phase followed by an execute phase for shifts. It drives the buffer register's cnt0, cnt1, en, init, shift_op and shift_counter_lsb controls and owns the dbus cycle handshake.

Parameters:
BITS_PER_CYCLE, 1, datapath width per cycle; legal values 1 or 4
LB, $clog2(BITS_PER_CYCLE), derived; width of the sub-word shift field
TIMEOUT_CYCLES, 255, dbus watchdog limit; used only with the optional feature

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  start request; accepted only in IDLE
i_op  in  2  00 addr-only, 01 load, 10 store, 11 shift
i_shamt  in  5  shift amount, sampled at start
i_right_shift  in  1  shift direction, sampled at start
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse on the final cycle of the operation
o_en  out  1  buffer-register enable
o_init  out  1  buffer-register init
o_cnt0  out  1  phase counter == 0 during INIT/EXEC
o_cnt1  out  1  phase counter == 1 during INIT/EXEC
o_shift_op  out  1  shift in progress
o_right_shift_op  out  1  registered i_right_shift
o_shift_counter_lsb  out  LB+1  {1'b0, shamt[LB-1:0]}; all-zero when LB=0
o_dbus_cyc  out  1  data bus request
i_dbus_ack  in  1  data bus acknowledge
o_err  out  1  watchdog abort pulse; constant 0 without the optional feature

Behaviour:
- Reset, and any cycle with i_rst=1 (including mid-operation): state=IDLE, counter=0, all outputs 0. o_dbus_cyc drops at that edge.
- Phase counter: 5-LB bits wide, cleared on every phase entry. A phase of N cycles covers counter values 0..N-1.
- IDLE: outputs 0. If i_start=1: latch op, shamt and right_shift, then go to INIT.
- INIT: 32/W cycles with en=1, init=1, and shift_op=1 when op=shift.
  - Last cycle, addr-only: o_done=1, next state IDLE.
  - Last cycle, load/store: next state MEM.
  - Last cycle, shift with shamt[4:LB]==0: next state EXEC; otherwise next state SKIP.
- MEM: o_dbus_cyc=1, en=0. On i_dbus_ack=1: o_done=1 in that cycle, next state IDLE. The minimum MEM dwell is 1 cycle.
- SKIP: shamt[4:LB] cycles with en=1, init=0, shift_op=1. Discards whole-word-aligned bits. Then EXEC.
- EXEC: 32/W cycles with en=1, init=0, shift_op=1. o_shift_counter_lsb is valid throughout. o_done=1 on the last cycle, next state IDLE.
- Latency from the start cycle to the done cycle:
  - addr-only: 32/W cycles
  - load/store: 32/W + wait cycles (at least 1)
  - shift: 32/W + shamt[4:LB] + 32/W cycles
- i_start while busy is ignored, and so is i_start in the o_done cycle. A new start is accepted the cycle after o_done.
- i_dbus_ack outside MEM is ignored. Ack in the first MEM cycle completes immediately.
- o_cnt0 and o_cnt1 are never asserted in MEM or SKIP. For W=4, o_cnt1 marks the second nibble.

Optional Feature:
SERV_BUFREG_CTRL_TIMEOUT_EN
- Defined:
  - A watchdog counter runs in MEM.
  - If TIMEOUT_CYCLES cycles pass without an ack: o_err=1 for one cycle, o_dbus_cyc drops, o_done=1 in the same cycle, next state IDLE.
  - An ack in the timeout cycle takes priority: normal done, no error.
- Undefined: no watchdog counter, o_err tied to 0, and MEM waits indefinitely.

Decomposition:
- Shared package holds:
  - the op encodings (OP_ADDR, OP_LOAD, OP_STORE, OP_SHIFT)
  - the state enum (IDLE, INIT, MEM, SKIP, EXEC)
  - a localparam for cycles per word (32/BITS_PER_CYCLE)
- One natural sub-module is serv_bufreg_ctrl_cnt: the phase counter with clear, last-value compare and cnt0/cnt1 decode. It is reusable by the watchdog.

Test Plan:
- W=1, start op=00 → en=init=1 for 32 cycles; cnt0 in cycle 0 and cnt1 in cycle 1; o_done in cycle 31; busy falls in cycle 32.
- W=1, op=01, ack held low 3 cycles after INIT, then high → dbus_cyc high 4 cycles; done coincides with ack; total 36 cycles.
- W=4, op=11, shamt=13 → INIT 8 cycles, SKIP 3, EXEC 8; shift_counter_lsb=3'b001; done in cycle 18.
- W=1, op=11, shamt=0 → SKIP bypassed; EXEC directly follows INIT; done in cycle 63.
- Reset asserted in MEM cycle 2 with dbus_cyc=1 → next cycle all outputs 0 and IDLE; start is accepted immediately after.
- TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack → o_err and o_done pulse in the 4th MEM cycle; with ack in that same cycle, o_err stays 0.

Source files
------------

// File: rtl/serv_bufreg_ctrl_pkg.sv
// Shared encodings for the SERV buffer-register sequencer: op codes, phase
// states and the cycles-per-word helper.
package serv_bufreg_ctrl_pkg;

  localparam logic [1:0] OP_ADDR  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  localparam int WORD_BITS = 32;

  typedef enum logic [2:0] {IDLE, INIT, MEM, SKIP, EXEC} state_t;

  function automatic int cycles_per_word(input int bpc);
    return WORD_BITS / bpc;
  endfunction

endpackage

// File: rtl/serv_bufreg_ctrl_cnt.sv
// Phase counter with synchronous clear, last-value compare and cnt0/cnt1
// decode; also used as the dbus watchdog.
module serv_bufreg_ctrl_cnt #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic         o_last,
  output logic         o_cnt0,
  output logic         o_cnt1
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_en)      r_cnt <= r_cnt + W'(1);
  end

  assign o_last = (r_cnt == i_last);
  assign o_cnt0 = (r_cnt == '0);
  assign o_cnt1 = (r_cnt == W'(1));

endmodule

// File: rtl/serv_bufreg_ctrl.sv
// Buffer-register sequencer: INIT, then MEM (load/store) or SKIP+EXEC (shift).
// Optional dbus watchdog enabled by defining SERV_BUFREG_CTRL_TIMEOUT_EN.
module serv_bufreg_ctrl
  import serv_bufreg_ctrl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int LB             = $clog2(BITS_PER_CYCLE),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic [4:0]    i_shamt,
  input  logic          i_right_shift,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_en,
  output logic          o_init,
  output logic          o_cnt0,
  output logic          o_cnt1,
  output logic          o_shift_op,
  output logic          o_right_shift_op,
  output logic [LB:0]   o_shift_counter_lsb,
  output logic          o_dbus_cyc,
  input  logic          i_dbus_ack,
  output logic          o_err
);

  localparam int CW  = 5 - LB;
  localparam int CPW = cycles_per_word(BITS_PER_CYCLE);

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_op;
  logic [4:0]     r_shamt;
  logic           r_right;
  logic [CW-1:0]  w_shamt_hi, w_last_val;
  logic           w_last, w_cnt0, w_cnt1, w_clr, w_timeout;

  assign w_shamt_hi = r_shamt[4:LB];
  assign w_last_val = (r_state == SKIP) ? (w_shamt_hi - CW'(1)) : CW'(CPW - 1);
  // Every phase starts from zero; IDLE keeps the counter parked there.
  assign w_clr      = (r_state == IDLE) || (w_state_nxt != r_state);

  serv_bufreg_ctrl_cnt #(.W(CW)) u_phase (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_en   (1'b1),
    .i_last (w_last_val),
    .o_last (w_last),
    .o_cnt0 (w_cnt0),
    .o_cnt1 (w_cnt1)
  );

`ifdef SERV_BUFREG_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic w_wd_last, w_wd_unused0, w_wd_unused1;

  serv_bufreg_ctrl_cnt #(.W(WDW)) u_wd (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (r_state != MEM),
    .i_en   (1'b1),
    .i_last (WDW'(TIMEOUT_CYCLES - 1)),
    .o_last (w_wd_last),
    .o_cnt0 (w_wd_unused0),
    .o_cnt1 (w_wd_unused1)
  );
  assign w_timeout = (r_state == MEM) && w_wd_last;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_op    <= OP_ADDR;
      r_shamt <= '0;
      r_right <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && i_start) begin
        r_op    <= i_op;
        r_shamt <= i_shamt;
        r_right <= i_right_shift;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    o_err       = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = INIT;
      INIT: if (w_last) begin
        case (r_op)
          OP_ADDR: begin o_done = 1'b1; w_state_nxt = IDLE; end
          OP_SHIFT: w_state_nxt = (w_shamt_hi == '0) ? EXEC : SKIP;
          default:  w_state_nxt = MEM;
        endcase
      end
      // Ack wins over a watchdog expiry in the same cycle.
      MEM: if (i_dbus_ack) begin
        o_done = 1'b1; w_state_nxt = IDLE;
      end else if (w_timeout) begin
        o_done = 1'b1; o_err = 1'b1; w_state_nxt = IDLE;
      end
      SKIP: if (w_last) w_state_nxt = EXEC;
      EXEC: if (w_last) begin o_done = 1'b1; w_state_nxt = IDLE; end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy           = (r_state != IDLE);
  assign o_en             = (r_state == INIT) || (r_state == SKIP) || (r_state == EXEC);
  assign o_init           = (r_state == INIT);
  assign o_cnt0           = ((r_state == INIT) || (r_state == EXEC)) && w_cnt0;
  assign o_cnt1           = ((r_state == INIT) || (r_state == EXEC)) && w_cnt1;
  assign o_shift_op       = (r_state == SKIP) || (r_state == EXEC) ||
                            ((r_state == INIT) && (r_op == OP_SHIFT));
  assign o_right_shift_op = o_busy && r_right;
  assign o_dbus_cyc       = (r_state == MEM);

  if (LB == 0) begin : g_lsb0
    assign o_shift_counter_lsb = '0;
  end else begin : g_lsb
    assign o_shift_counter_lsb = o_busy ? {1'b0, r_shamt[LB-1:0]} : '0;
  end

endmodule
